// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-in/serial-out shift register built from mx2 cells

// rtl/piso_shift_reg.sv - 2:1 mux cell used for every next-state bit
module mx2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// rtl/piso_shift_reg.sv - ready/valid loaded serializer, one bit per enabled clock
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] neigh;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic             shift_sel;
  logic             load_sel;

  // Zero-filled neighbour bit each position takes when shifting toward sout.
  if (LSB_FIRST != 0) begin : g_lsb
    assign neigh = {1'b0, sreg[WIDTH-1:1]};
  end else begin : g_msb
    assign neigh = {sreg[WIDTH-2:0], 1'b0};
  end

  assign shift_sel = en & (state == SHIFT);
  assign load_sel  = ld_valid & ld_ready;

  // Per bit: hold vs. shift first, then that result vs. the parallel word.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mx2 u_hold_shift (
      .d0 (sreg[i]),
      .d1 (neigh[i]),
      .s  (shift_sel),
      .y  (shift_nxt[i])
    );
    mx2 u_load (
      .d0 (shift_nxt[i]),
      .d1 (ld_data[i]),
      .s  (load_sel),
      .y  (d_nxt[i])
    );
  end

  // Shift register; reset clears it after the mux tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else begin
      sreg <= d_nxt;
    end
  end

  // FSM state and bit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and outputs; en only matters while shifting.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ld_ready   = (state == IDLE) & ~rst;
    sout_valid = (state == SHIFT);
    last       = (state == SHIFT) & (cnt == CNT_LAST);
    sout       = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
    case (state)
      IDLE: begin
        if (ld_valid & ld_ready) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb/tb_piso_shift_reg.sv - scoreboard bench for MSB-first and LSB-first serializers
module tb_piso_shift_reg;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_valid;
  logic [W-1:0] ld_data;
  logic         en;

  logic m_ld_ready, m_sout, m_sout_valid, m_last;
  logic l_ld_ready, l_sout, l_sout_valid, l_last;

  int compared   = 0;
  int mismatched = 0;

  exp_t qm[$];
  exp_t ql[$];
  exp_t em, el;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (m_ld_ready),
    .en         (en),
    .sout       (m_sout),
    .sout_valid (m_sout_valid),
    .last       (m_last)
  );

  piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (l_ld_ready),
    .en         (en),
    .sout       (l_sout),
    .sout_valid (l_sout_valid),
    .last       (l_last)
  );

  // Scoreboard: compare the head while a bit is valid, pop when en consumes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_sout_valid) begin
        compared++;
        if (qm.size() == 0) begin
          mismatched++;
          $display("FAIL msb_unexpected_bit: got sout=%0b last=%0b, required no valid bit", m_sout, m_last);
        end else begin
          em = qm[0];
          if ({m_sout, m_last} !== {em.b, em.l}) begin
            mismatched++;
            $display("FAIL msb_bit: got sout=%0b last=%0b, required sout=%0b last=%0b", m_sout, m_last, em.b, em.l);
          end
          if (en) void'(qm.pop_front());
        end
      end
      if (l_sout_valid) begin
        compared++;
        if (ql.size() == 0) begin
          mismatched++;
          $display("FAIL lsb_unexpected_bit: got sout=%0b last=%0b, required no valid bit", l_sout, l_last);
        end else begin
          el = ql[0];
          if ({l_sout, l_last} !== {el.b, el.l}) begin
            mismatched++;
            $display("FAIL lsb_bit: got sout=%0b last=%0b, required sout=%0b last=%0b", l_sout, l_last, el.b, el.l);
          end
          if (en) void'(ql.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b = w[W-1-i];
      e.l = (i == W - 1);
      qm.push_back(e);
      e.b = w[i];
      ql.push_back(e);
    end
  endtask

  task automatic load_word(input logic [W-1:0] w);
    ld_valid = 1'b1;
    ld_data  = w;
    push_word(w);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; en = 1'b0;
    tick(); tick();
    compared++;
    if ({m_ld_ready, m_sout_valid, m_sout, m_last, l_ld_ready, l_sout_valid, l_sout, l_last} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got msb=%b lsb=%b, required 0000/0000",
               {m_ld_ready, m_sout_valid, m_sout, m_last}, {l_ld_ready, l_sout_valid, l_sout, l_last});
    end
    rst = 1'b0;
    #1;
    compared++;
    if ({m_ld_ready, l_ld_ready} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b, required 11", {m_ld_ready, l_ld_ready});
    end
    en = 1'b1;
    load_word(8'h5A);
    tick(); tick();
    rst = 1'b1;
    qm.delete(); ql.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({m_ld_ready, m_sout_valid, m_sout, m_last, l_ld_ready, l_sout_valid, l_sout, l_last} !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_mid_stream_%0d: got msb=%b lsb=%b, required 0000/0000", k,
                 {m_ld_ready, m_sout_valid, m_sout, m_last}, {l_ld_ready, l_sout_valid, l_sout, l_last});
      end
    end
    rst = 1'b0;
    #1;
    compared++;
    if ({m_ld_ready, l_ld_ready} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_first_cycle_ready: got %b, required 11", {m_ld_ready, l_ld_ready});
    end
  endtask

  task automatic test_basic;
    en = 1'b1;
    load_word(8'hA5);
    for (int k = 1; k <= W; k++) begin
      compared++;
      if ({m_sout_valid, m_last, l_sout_valid, l_last} !== {1'b1, k == W, 1'b1, k == W}) begin
        mismatched++;
        $display("FAIL basic_cycle_%0d: got valid/last msb=%b lsb=%b, required %b", k,
                 {m_sout_valid, m_last}, {l_sout_valid, l_last}, {1'b1, k == W});
      end
      tick();
    end
    compared++;
    if ({m_ld_ready, m_sout_valid, l_ld_ready, l_sout_valid} !== 4'b1010) begin
      mismatched++;
      $display("FAIL basic_ready_cycle9: got %b, required 1010", {m_ld_ready, m_sout_valid, l_ld_ready, l_sout_valid});
    end
    load_word(8'h01);
    repeat (W) tick();
    compared++;
    if (qm.size() != 0 || ql.size() != 0 || {m_ld_ready, l_ld_ready} !== 2'b11) begin
      mismatched++;
      $display("FAIL basic_drain: got pending %0d/%0d ready=%b, required 0/0 ready=11",
               qm.size(), ql.size(), {m_ld_ready, l_ld_ready});
    end
  endtask

  task automatic test_stall;
    int lm;
    int ll;
    int n;
    lm = 0; ll = 0; n = 0;
    en = 1'b1;
    load_word(8'hF0);
    tick(); tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({m_sout_valid, m_sout, m_last, l_sout_valid, l_sout, l_last} !== 6'b110_100) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: got msb=%b lsb=%b, required 110/100", k,
                 {m_sout_valid, m_sout, m_last}, {l_sout_valid, l_sout, l_last});
      end
    end
    en = 1'b1;
    while (!(m_ld_ready && l_ld_ready) && n < 30) begin
      lm += int'(m_last);
      ll += int'(l_last);
      tick();
      n++;
    end
    compared++;
    if (lm != 1 || ll != 1 || n != 6 || qm.size() != 0 || ql.size() != 0) begin
      mismatched++;
      $display("FAIL stall_last_once: got last msb=%0d lsb=%0d cycles=%0d pending=%0d/%0d, required 1 1 6 0/0",
               lm, ll, n, qm.size(), ql.size());
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    n = 0;
    en = 1'b1;
    load_word(8'hC3);
    tick();
    ld_valid = 1'b1;
    ld_data  = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if ({m_ld_ready, l_ld_ready} !== 2'b00) begin
        mismatched++;
        $display("FAIL busy_ready_%0d: got %b, required 00", k, {m_ld_ready, l_ld_ready});
      end
      tick();
    end
    ld_valid = 1'b0;
    while (!(m_ld_ready && l_ld_ready) && n < 30) begin
      tick();
      n++;
    end
    repeat (2) tick();
    compared++;
    if (n != 5 || qm.size() != 0 || ql.size() != 0 || m_sout_valid !== 1'b0 || l_sout_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_ignore: got cycles=%0d pending=%0d/%0d valid=%b, required 5 0/0 00",
               n, qm.size(), ql.size(), {m_sout_valid, l_sout_valid});
    end
  endtask

  task automatic test_back_to_back;
    int n;
    n = 0;
    en = 1'b1;
    load_word(8'hFF);
    tick(); tick(); tick();
    rst = 1'b1;
    qm.delete(); ql.delete();
    tick();
    compared++;
    if ({m_ld_ready, m_sout_valid, m_sout, m_last, l_ld_ready, l_sout_valid, l_sout, l_last} !== 8'h00) begin
      mismatched++;
      $display("FAIL b2b_reset_clear: got msb=%b lsb=%b, required 0000/0000",
               {m_ld_ready, m_sout_valid, m_sout, m_last}, {l_ld_ready, l_sout_valid, l_sout, l_last});
    end
    rst = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 8'h81;
    push_word(8'h81);
    tick();
    ld_data = 8'h7E;
    push_word(8'h7E);
    for (int k = 1; k <= W; k++) begin
      compared++;
      if ({m_ld_ready, l_ld_ready} !== 2'b00) begin
        mismatched++;
        $display("FAIL b2b_no_overlap_%0d: got %b, required 00", k, {m_ld_ready, l_ld_ready});
      end
      tick();
    end
    compared++;
    if ({m_ld_ready, l_ld_ready} !== 2'b11) begin
      mismatched++;
      $display("FAIL b2b_ready_at_w_plus_1: got %b, required 11", {m_ld_ready, l_ld_ready});
    end
    tick();
    ld_valid = 1'b0;
    compared++;
    if ({m_sout_valid, l_sout_valid} !== 2'b11) begin
      mismatched++;
      $display("FAIL b2b_second_accepted: got %b, required 11", {m_sout_valid, l_sout_valid});
    end
    while (!(m_ld_ready && l_ld_ready) && n < 30) begin
      tick();
      n++;
    end
    compared++;
    if (n != W || qm.size() != 0 || ql.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_drain: got cycles=%0d pending=%0d/%0d, required %0d 0/0", n, qm.size(), ql.size(), W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy_ignore();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
